// File: rtl/serial_to_parallel_if.sv
// Serial input, clear and parallel valid/ready output bundle of the deserializer.
// The master side feeds bits and consumes words; the slave side is the deserializer.
interface serial_to_parallel_if #(
    parameter int WIDTH = 4
);
    logic             serial_i;
    logic             valid_i;
    logic             clear_i;
    logic [WIDTH-1:0] parallel_o;
    logic             pvalid_o;
    logic             pready_i;
    logic             busy_o;
    logic             overflow_o;

    modport master (
        output serial_i, valid_i, clear_i, pready_i,
        input  parallel_o, pvalid_o, busy_o, overflow_o
    );

    modport slave (
        input  serial_i, valid_i, clear_i, pready_i,
        output parallel_o, pvalid_o, busy_o, overflow_o
    );
endinterface

// File: rtl/serial_to_parallel.sv
// LSB-first deserializer: gathers WIDTH valid bits into a word and hands it
// over through a one-entry valid/ready register, flagging frames dropped on stall.
module serial_to_parallel #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic                 clk,
    input logic                 reset,
    serial_to_parallel_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_ff;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] word;
    logic             cap;
    logic             done;

    assign cap  = bus.valid_i & ~bus.clear_i;
    assign done = cap & (cnt == LAST);
    assign word = {bus.serial_i, shift_ff[WIDTH-1:1]};

    // clear_i wins over a same-cycle bit so the restarted frame begins clean
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_ff <= '0;
            cnt      <= '0;
        end else if (bus.clear_i) begin
            shift_ff <= '0;
            cnt      <= '0;
        end else if (bus.valid_i) begin
            shift_ff <= word;
            cnt      <= done ? '0 : cnt + CNT_W'(1);
        end
    end

    // A completing frame may replace a word being consumed in the same cycle;
    // otherwise a stalled register forces the new word to be dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.parallel_o <= '0;
            bus.pvalid_o   <= 1'b0;
            bus.overflow_o <= 1'b0;
        end else begin
            bus.overflow_o <= 1'b0;
            if (done) begin
                if (!bus.pvalid_o || bus.pready_i) begin
                    bus.parallel_o <= word;
                    bus.pvalid_o   <= 1'b1;
                end else begin
                    bus.overflow_o <= 1'b1;
                end
            end else if (bus.pvalid_o && bus.pready_i) begin
                bus.pvalid_o <= 1'b0;
            end
        end
    end

    assign bus.busy_o = (cnt != '0);
endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Deserializer placed directly downstream of the 4-bit parallel-to-serial stage.
- Collects LSB-first serial bits qualified by valid_i into WIDTH-bit words.
- Presents each completed word on a one-entry valid/ready output register.
- Flags frames lost to back-pressure, and supports a synchronous partial-frame clear.

Parameters:
- WIDTH, 4: bits per frame. Legal range ≥ 2. The default matches the upstream serializer.
- CNT_W, $clog2(WIDTH): bit-counter width. Derived; must not be overridden.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- reset  input  1  Asynchronous, active-low reset. All state clears while low.
- serial_i  input  1  Serial data bit. LSB of the frame arrives first.
- valid_i  input  1  serial_i carries a frame bit this cycle.
- clear_i  input  1  Synchronous abort of the partial frame.
- parallel_o  output  WIDTH  Assembled word. Stable while pvalid_o=1 and pready_i=0.
- pvalid_o  output  1  parallel_o holds an unconsumed word.
- pready_i  input  1  Consumer accepts the word this cycle when pvalid_o=1.
- busy_o  output  1  A partial frame is in progress (bit counter ≠ 0).
- overflow_o  output  1  One-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset (reset=0, asynchronous): shift register=0, bit counter=0, parallel_o=0, pvalid_o=0, busy_o=0, overflow_o=0.
- Bit capture when valid_i=1 and clear_i=0:
  - shift_ff <= {serial_i, shift_ff[WIDTH-1:1]}.
  - Counter increments.
- Gaps: when valid_i=0, shift_ff and the counter hold. Gaps of any length inside a frame are legal.
- Frame completion:
  - Occurs when valid_i=1 and counter==WIDTH-1.
  - word = {serial_i, shift_ff[WIDTH-1:1]}.
  - Counter wraps to 0.
  - Shift register contents after wrap are don't-care.
- Output register load on completion:
  - Loads when pvalid_o=0, or when pvalid_o=1 and pready_i=1 in the same cycle.
  - On load: parallel_o <= word and pvalid_o <= 1 at the next edge. Completion-to-pvalid_o latency is 1 cycle.
- Overflow on completion:
  - Condition: pvalid_o=1 and pready_i=0.
  - The word is discarded. parallel_o and pvalid_o are unchanged.
  - overflow_o=1 for exactly the next cycle.
- Handshake:
  - Transfer happens when pvalid_o & pready_i.
  - With no simultaneous completion, pvalid_o <= 0 next cycle and parallel_o holds its last value.
  - pready_i is ignored while pvalid_o=0.
  - pvalid_o never drops without a transfer, except on reset.
- clear_i=1:
  - Counter <= 0 and shift_ff <= 0. The valid_i bit in the same cycle is discarded.
  - The output register and pvalid_o are unaffected.
  - clear_i has priority over valid_i.
- busy_o = (counter ≠ 0), driven combinationally from the registered counter.
- Upstream compatibility: the 4-bit serializer emits 4 valid bits then 1 idle cycle. Sustained input rate is 1 word per 5 cycles. With pready_i tied high, overflow_o never fires.
- Reset mid-frame: the partial frame is lost. The next valid_i bit is treated as bit 0.

Test Plan (WIDTH=4):
- Single frame:
  - Stimulus: reset released; valid_i=1 for 4 cycles with serial_i=1,1,0,1; pready_i=0.
  - Response: pvalid_o=1 one cycle after the 4th bit, parallel_o=4'hB. Values hold until pready_i=1, then pvalid_o=0 next cycle.
- Back-to-back with upstream serializer:
  - Stimulus: upstream feeds parallel_i=4'h5 then 4'hA; pready_i=1.
  - Response: parallel_o=4'h5 then 4'hA, each pvalid_o pulse 1 cycle wide, 5 cycles apart; overflow_o stays 0.
- Gapped input:
  - Stimulus: 4 bits 0,1,1,0 with valid_i=0 for 3 cycles between bits 2 and 3.
  - Response: parallel_o=4'h6, busy_o=1 throughout the gap.
- Overflow:
  - Stimulus: frame 4'h3 accepted into the output register; pready_i=0; a second frame 4'hC completes.
  - Response: overflow_o=1 for 1 cycle, parallel_o stays 4'h3.
  - Follow-up: completion with pready_i=1 in the same cycle loads the new word, pvalid_o stays 1.
- Clear:
  - Stimulus: 2 bits sent, then clear_i=1 together with valid_i=1, then 4 bits 1,0,0,1.
  - Response: busy_o=0 after the clear, parallel_o=4'h9.
- Reset mid-frame:
  - Stimulus: reset driven low after 3 bits, with pvalid_o=1 holding 4'h7.
  - Response: all outputs 0 immediately (asynchronous). The next 4 bits 0,0,1,0 give parallel_o=4'h4.
